// File: rtl/error_collector.sv
// Error collector: sticky per-source pending bits, priority-encoded report to the PCU with valid/ack.
// Optional per-source PC capture is enabled by defining ERROR_PC_CAPTURE_EN.
module error_collector #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned CODE_W  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] err_req,
    input  logic [NUM_SRC-1:0] err_mask,
    input  logic [DATA_W-1:0]  cur_pc,
    input  logic               pcu_ack,
    output logic [CODE_W-1:0]  cpu_error,
    output logic               err_valid,
    output logic [DATA_W-1:0]  err_pc,
    output logic               halt_req,
    output logic [NUM_SRC-1:0] err_pending,
    output logic               err_overflow,
    output logic [CNT_W-1:0]   err_count
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REPORT,
        GAP
    } state_t;

    state_t             state;
    state_t             state_next;

    logic               ack_take;
    logic               reload;
    logic [NUM_SRC-1:0] new_err;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] load;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] overflow_hit;
    logic               win_any;
    logic [IDX_W-1:0]   win_idx;
    logic [CODE_W-1:0]  win_code;

    // A set and a clear on the same source in one cycle leaves it pending with a fresh PC.
    always_comb begin
        ack_take = (state == REPORT) && pcu_ack;
        new_err  = err_req & ~err_mask;
        clr      = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            clr[i] = ack_take && (cpu_error == CODE_W'(i + 1));
        end
        load         = new_err & (~err_pending | clr);
        overflow_hit = new_err & err_pending & ~clr;
        pending_next = (err_pending & ~clr) | new_err;
    end

    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pending_next[i] && !win_any) begin
                win_any = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
        win_code = CODE_W'(win_idx) + CODE_W'(1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_any) state_next = REPORT;
            REPORT:  if (pcu_ack) state_next = GAP;
            GAP:     state_next = win_any ? REPORT : IDLE;
            default: state_next = IDLE;
        endcase
        reload = (state_next == REPORT) && (state != REPORT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_error    <= '0;
            err_valid    <= 1'b0;
            halt_req     <= 1'b0;
            err_pending  <= '0;
            err_overflow <= 1'b0;
            err_count    <= '0;
        end else begin
            err_valid   <= (state_next == REPORT);
            halt_req    <= (state_next != IDLE);
            err_pending <= pending_next;
            if (reload) begin
                cpu_error <= win_code;
            end else if (state_next != REPORT) begin
                cpu_error <= '0;
            end
            if (|overflow_hit) begin
                err_overflow <= 1'b1;
            end
            if (ack_take && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

`ifdef ERROR_PC_CAPTURE_EN
    logic [DATA_W-1:0] pc_q [NUM_SRC];
    logic [DATA_W-1:0] win_pc;

    always_comb begin
        win_pc = load[win_idx] ? cur_pc : pc_q[win_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                pc_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (load[i]) begin
                    pc_q[i] <= cur_pc;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pc <= '0;
        end else if (reload) begin
            err_pc <= win_pc;
        end else if (state_next != REPORT) begin
            err_pc <= '0;
        end
    end
`else
    logic unused_pc;

    assign unused_pc = ^{cur_pc, load};
    assign err_pc    = '0;
`endif

endmodule

// File: doc/error_collector.md
Name: error_collector

Overview:
- Parametrised successor to the CPU error-code block.
- Collects NUM_SRC error sources (CCU, CU, IMU, DMU, …) into sticky pending bits and reports them one at a time to the PCU as a priority-encoded code.
- Reporting uses a valid/ack handshake and can capture the PC for each source.
- Sits between the datapath error outputs and the PCU; drives halt_req while an error is awaiting acknowledgement.

Parameters:
- NUM_SRC, 4, number of error sources; index 0 = highest priority.
- CODE_W, 4, width of the error code; must satisfy 2^CODE_W > NUM_SRC.
- DATA_W, 32, PC width.
- CNT_W, 8, width of the saturating total-error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- err_req  input  NUM_SRC  per-source error request, sampled each cycle (level or pulse).
- err_mask  input  NUM_SRC  1 = source ignored at capture.
- cur_pc  input  DATA_W  PC of the instruction raising the error this cycle.
- pcu_ack  input  1  PCU accepts the currently reported error.
- cpu_error  output  CODE_W  reported code; 0 = no error, source i → i+1.
- err_valid  output  1  cpu_error/err_pc valid.
- err_pc  output  DATA_W  PC captured for the reported source.
- halt_req  output  1  request to freeze the pipeline.
- err_pending  output  NUM_SRC  sticky pending bits.
- err_overflow  output  1  sticky: a request arrived for an already-pending source.
- err_count  output  CNT_W  saturating count of accepted (pcu_ack'ed) errors.

Behaviour:
- All outputs are registered. Reset (async, any state, mid-handshake included) clears:
  - state → IDLE;
  - cpu_error, err_valid, halt_req, err_pending, err_overflow, err_count, err_pc → 0;
  - PC array → 0.
- Capture, every cycle:
  - new = err_req & ~err_mask.
  - For each bit i of new: if pending[i] is 0, set pending[i] and store cur_pc in pc[i]; if pending[i] is already 1, leave pc[i] unchanged and set err_overflow.
  - Mask applies only at capture; an already-pending source is still reported after it becomes masked.
- Priority: the lowest-index pending bit wins. Code = index+1, width CODE_W.
- FSM states IDLE, REPORT, GAP:
  - IDLE: err_valid=0, halt_req=0. If pending (including bits set this cycle) is nonzero, go to REPORT. The winning code and PC are loaded into cpu_error/err_pc at that edge.
  - REPORT: err_valid=1, halt_req=1. cpu_error/err_pc are held stable regardless of new arrivals, including higher-priority ones.
    - pcu_ack=1: clear pending[code-1], increment err_count (saturates at all-ones), go to GAP.
    - pcu_ack=0: stay.
  - GAP: one cycle, err_valid=0, halt_req=1, cpu_error=0. Next state is REPORT (reload the new winner) if pending is nonzero, else IDLE.
- Latency:
  - err_req high in cycle n from IDLE → err_valid high in cycle n+1.
  - pcu_ack in cycle m → err_valid low in m+1 and, if more errors are pending, high again in m+2.
- Simultaneous set/clear: if pcu_ack and a new unmasked request hit the same source in the same cycle, set wins. The bit stays pending, pc[i] is reloaded with cur_pc, and err_overflow is not set.
- Ack outside REPORT is ignored.
- err_overflow clears only on rst.

Optional Feature:
- Macro ERROR_PC_CAPTURE_EN.
- Defined: per-source PC array of NUM_SRC×DATA_W bits; err_pc follows the rules above.
- Undefined: no PC storage; err_pc is constant 0; all other behaviour is identical.

Test Plan (NUM_SRC=4, CODE_W=4, ERROR_PC_CAPTURE_EN defined unless stated):
- Single error: err_req=4'b0100 for 1 cycle with cur_pc=0x0000_1000 → next cycle cpu_error=3, err_valid=1, halt_req=1, err_pc=0x1000. Hold ack low 5 cycles → outputs stable. Ack → GAP cycle with err_valid=0, then IDLE; err_count=1, err_pending=0.
- Priority and queuing:
  - err_req=4'b1010 at pc 0x20 → report code 2.
  - Inject 4'b0001 at pc 0x24 during REPORT → code stays 2.
  - Ack → GAP → code 1 (pc 0x24) → ack → GAP → code 4 (pc 0x20) → ack → IDLE; err_count=3.
- Mask and overflow: err_mask=4'b0001 with err_req=4'b0001 → no report, err_pending=0. Source 1 raised twice while pending → err_overflow=1 and err_pc keeps the first PC.
- Set-over-clear: in REPORT code 2, assert pcu_ack and err_req=4'b0010 with pc 0x40 in the same cycle → after GAP, code 2 is reported again with err_pc=0x40; err_overflow=0.
- Async reset mid-REPORT: assert rst between clock edges → all outputs 0 immediately, without waiting for an edge; an err_req after release is reported normally.
- Compile without ERROR_PC_CAPTURE_EN, repeat the first scenario → err_pc=0, all else identical; also drive err_count to 255 via 256 ack'ed errors → count stays 255.
